// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue stage: op codes, branch conditions and
// the branch-condition evaluator used against the architectural flags.
// Ports: none (package).
package alu_pkg;

  localparam int DATA_W = 16;

  // ALU operation encodings
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_LHB = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  // Branch condition encodings
  localparam logic [2:0] COND_NE     = 3'b000;
  localparam logic [2:0] COND_EQ     = 3'b001;
  localparam logic [2:0] COND_GT     = 3'b010;
  localparam logic [2:0] COND_LT     = 3'b011;
  localparam logic [2:0] COND_GE     = 3'b100;
  localparam logic [2:0] COND_LE     = 3'b101;
  localparam logic [2:0] COND_OV     = 3'b110;
  localparam logic [2:0] COND_UNCOND = 3'b111;

  function automatic logic eval_cond(input logic [2:0] cond,
                                     input logic z, input logic v, input logic n);
    logic taken;
    taken = 1'b0;
    case (cond)
      COND_NE:     taken = !z;
      COND_EQ:     taken = z;
      COND_GT:     taken = !z && !n;
      COND_LT:     taken = n;
      COND_GE:     taken = z || !n;
      COND_LE:     taken = n || z;
      COND_OV:     taken = v;
      default:     taken = 1'b1;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/alu_issue_alu.sv
// Purpose: combinational 16-bit ALU with saturating ADD/SUB.
// Latency: 0 cycles (pure combinational). Backpressure: none, no state.
// Ports: i_op/i_src0/i_src1/i_shamt in; o_dst result, o_ov signed overflow
//        (ADD/SUB only), o_zr result-is-zero (after saturation).
module alu_issue_alu
  import alu_pkg::*;
(
  input  logic [2:0]        i_op,
  input  logic [DATA_W-1:0] i_src0,
  input  logic [DATA_W-1:0] i_src1,
  input  logic [3:0]        i_shamt,
  output logic [DATA_W-1:0] o_dst,
  output logic              o_ov,
  output logic              o_zr
);

  logic              w_sub;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_sum;
  logic              w_ov;

  // SUB reuses the adder as a + ~b + 1
  assign w_sub = (i_op == OP_SUB);
  assign w_b   = w_sub ? ~i_src1 : i_src1;
  assign w_sum = i_src0 + w_b + {{(DATA_W-1){1'b0}}, w_sub};
  // Overflow when both adder inputs share a sign that the sum does not
  assign w_ov  = (i_src0[DATA_W-1] == w_b[DATA_W-1]) &&
                 (w_sum[DATA_W-1] != i_src0[DATA_W-1]);

  always_comb begin
    o_dst = '0;
    o_ov  = 1'b0;
    case (i_op)
      OP_ADD, OP_SUB: begin
        o_ov = w_ov;
        // Saturate toward the sign of src0 (the true result's sign)
        if (w_ov) o_dst = i_src0[DATA_W-1] ? 16'h8000 : 16'h7FFF;
        else      o_dst = w_sum;
      end
      OP_LHB:  o_dst = {i_src1[15:8], i_src0[7:0]};
      OP_AND:  o_dst = i_src0 & i_src1;
      OP_NOR:  o_dst = ~(i_src0 | i_src1);
      OP_SLL:  o_dst = i_src0 << i_shamt;
      OP_SRL:  o_dst = i_src0 >> i_shamt;
      default: o_dst = $signed(i_src0) >>> i_shamt;
    endcase
  end

  assign o_zr = (o_dst == '0);

endmodule

// File: rtl/alu_issue.sv
// Purpose: single-entry ALU issue stage with flag register and branch resolve.
// Latency: 1 cycle from accepted instruction to registered result.
// Backpressure: in_ready = !out_valid | out_ready; stalled result held stable.
// Ports: clk/rst (sync, active-high); in_* instruction with valid/ready;
//        out_* registered result with valid/ready; flag_z/v/n architectural flags.
module alu_issue
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [DATA_W-1:0] in_src0,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [3:0]        in_shamt,
  input  logic [3:0]        in_dst_reg,
  input  logic              in_we,
  input  logic              in_br,
  input  logic [2:0]        in_cond,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_dst_reg,
  output logic              out_we,
  output logic              out_taken,
  output logic              flag_z,
  output logic              flag_v,
  output logic              flag_n
);

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [3:0]        r_out_dst_reg;
  logic              r_out_we;
  logic              r_out_taken;
  logic              r_flag_z;
  logic              r_flag_v;
  logic              r_flag_n;

  logic [DATA_W-1:0] w_dst;
  logic              w_ov;
  logic              w_zr;
  logic              w_ready;
  logic              w_xfer;
  logic              w_taken;

  alu_issue_alu u_alu (
    .i_op    (in_op),
    .i_src0  (in_src0),
    .i_src1  (in_src1),
    .i_shamt (in_shamt),
    .o_dst   (w_dst),
    .o_ov    (w_ov),
    .o_zr    (w_zr)
  );

  // rst term keeps in_ready high before the first reset edge has cleared out_valid
  assign w_ready = rst || !r_out_valid || out_ready;
  assign w_xfer  = in_valid && w_ready;
  // Flags seen here already include every previously accepted instruction
  assign w_taken = eval_cond(in_cond, r_flag_z, r_flag_v, r_flag_n);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_dst_reg <= '0;
      r_out_we      <= 1'b0;
      r_out_taken   <= 1'b0;
      r_flag_z      <= 1'b0;
      r_flag_v      <= 1'b0;
      r_flag_n      <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid   <= 1'b1;
      r_out_data    <= in_br ? '0 : w_dst;
      r_out_dst_reg <= in_dst_reg;
      r_out_we      <= in_we && !in_br;
      r_out_taken   <= in_br ? w_taken : 1'b0;
      if (!in_br) begin
        case (in_op)
          OP_ADD, OP_SUB: begin
            r_flag_z <= w_zr;
            r_flag_v <= w_ov;
            r_flag_n <= w_dst[DATA_W-1];
          end
          OP_LHB:  ;
          default: r_flag_z <= w_zr;
        endcase
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready    = w_ready;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_dst_reg = r_out_dst_reg;
  assign out_we      = r_out_we;
  assign out_taken   = r_out_taken;
  assign flag_z      = r_flag_z;
  assign flag_v      = r_flag_v;
  assign flag_n      = r_flag_n;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: hand-computed vectors checked with immediate
// assertions after each clock edge.
module tb_alu_issue;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [15:0] in_src0;
  logic [15:0] in_src1;
  logic [3:0]  in_shamt;
  logic [3:0]  in_dst_reg;
  logic        in_we;
  logic        in_br;
  logic [2:0]  in_cond;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_dst_reg;
  logic        out_we;
  logic        out_taken;
  logic        flag_z;
  logic        flag_v;
  logic        flag_n;

  int errors = 0;
  int checks = 0;

  alu_issue dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_src0(in_src0), .in_src1(in_src1), .in_shamt(in_shamt),
    .in_dst_reg(in_dst_reg), .in_we(in_we), .in_br(in_br), .in_cond(in_cond),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_dst_reg(out_dst_reg), .out_we(out_we),
    .out_taken(out_taken),
    .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic z, input logic v, input logic n);
    chk1({tag, ".z"}, flag_z, z);
    chk1({tag, ".v"}, flag_v, v);
    chk1({tag, ".n"}, flag_n, n);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a non-branch ALU instruction
  task automatic alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                     input logic [3:0] sh, input logic [3:0] dst);
    in_valid = 1'b1; in_op = op; in_src0 = a; in_src1 = b; in_shamt = sh;
    in_dst_reg = dst; in_we = 1'b1; in_br = 1'b0; in_cond = COND_NE;
  endtask

  // Present a branch; operands are deliberately nonzero to show they are ignored
  task automatic br(input logic [2:0] cond);
    in_valid = 1'b1; in_op = OP_ADD; in_src0 = 16'h1234; in_src1 = 16'h0001;
    in_shamt = 4'd0; in_dst_reg = 4'd9; in_we = 1'b1; in_br = 1'b1; in_cond = cond;
  endtask

  // Issue one ALU op with out_ready=1 and check result and flags
  task automatic run_alu(input string tag, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] sh,
                         input logic [15:0] exp, input logic z, input logic v, input logic n);
    alu(op, a, b, sh, 4'd2);
    tick();
    chk16({tag, ".data"}, out_data, exp);
    chk_flags(tag, z, v, n);
  endtask

  // Issue one branch and check taken, out_we, out_data
  task automatic run_br(input string tag, input logic [2:0] cond, input logic exp_taken);
    br(cond);
    tick();
    chk1({tag, ".taken"}, out_taken, exp_taken);
    chk1({tag, ".we"}, out_we, 1'b0);
    chk16({tag, ".data"}, out_data, 16'h0000);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_op = OP_ADD; in_src0 = '0; in_src1 = '0; in_shamt = '0;
    in_dst_reg = '0; in_we = 1'b0; in_br = 1'b0; in_cond = COND_NE;
    #1;
    chk1("ready_before_edge", in_ready, 1'b1);
    tick(); tick();
    chk1("rst.valid", out_valid, 1'b0);
    chk16("rst.data", out_data, 16'h0000);
    chk16("rst.dst", {12'b0, out_dst_reg}, 16'h0000);
    chk1("rst.we", out_we, 1'b0);
    chk1("rst.taken", out_taken, 1'b0);
    chk_flags("rst", 1'b0, 1'b0, 1'b0);
    chk1("rst.ready", in_ready, 1'b1);
    rst = 1'b0;
    #1;
    chk1("post_rst.ready", in_ready, 1'b1);

    // Saturating add of two negatives
    alu(OP_ADD, 16'h8888, 16'h8888, 4'd0, 4'd3);
    tick();
    chk1("add_sat.valid", out_valid, 1'b1);
    chk16("add_sat.data", out_data, 16'h8000);
    chk16("add_sat.dst", {12'b0, out_dst_reg}, 16'h0003);
    chk1("add_sat.we", out_we, 1'b1);
    chk1("add_sat.taken", out_taken, 1'b0);
    chk_flags("add_sat", 1'b0, 1'b1, 1'b1);

    // Logical op touches only Z
    run_alu("and_zero", OP_AND, 16'hFFFF, 16'h0000, 4'd0, 16'h0000, 1'b1, 1'b1, 1'b1);
    run_alu("sub_eq", OP_SUB, 16'h0005, 16'h0005, 4'd0, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_br("br_eq", COND_EQ, 1'b1);
    chk_flags("br_eq", 1'b1, 1'b0, 1'b0);
    run_alu("lhb", OP_LHB, 16'h12AB, 16'h3400, 4'd0, 16'h34AB, 1'b1, 1'b0, 1'b0);
    run_br("br_le_z", COND_LE, 1'b1);
    run_br("br_gt_z", COND_GT, 1'b0);

    run_alu("add_small", OP_ADD, 16'h0001, 16'h0002, 4'd0, 16'h0003, 1'b0, 1'b0, 1'b0);
    run_br("br_gt", COND_GT, 1'b1);
    run_br("br_lt", COND_LT, 1'b0);
    run_br("br_ne", COND_NE, 1'b1);
    run_br("br_ov0", COND_OV, 1'b0);

    run_alu("sub_sat", OP_SUB, 16'h8000, 16'h0001, 4'd0, 16'h8000, 1'b0, 1'b1, 1'b1);
    run_br("br_ov1", COND_OV, 1'b1);
    run_br("br_ge", COND_GE, 1'b0);
    run_alu("add_psat", OP_ADD, 16'h7FFF, 16'h0001, 4'd0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    run_alu("sll", OP_SLL, 16'h0001, 16'h0000, 4'd15, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_alu("sra", OP_SRA, 16'h8000, 16'h0000, 4'd15, 16'hFFFF, 1'b0, 1'b1, 1'b0);
    run_alu("srl", OP_SRL, 16'h8000, 16'h0000, 4'd15, 16'h0001, 1'b0, 1'b1, 1'b0);
    run_alu("nor", OP_NOR, 16'h00FF, 16'h0F00, 4'd0, 16'hF000, 1'b0, 1'b1, 1'b0);
    run_alu("srl_zero", OP_SRL, 16'h0001, 16'h0000, 4'd1, 16'h0000, 1'b1, 1'b1, 1'b0);
    run_br("br_uncond", COND_UNCOND, 1'b1);

    // Stall: result held, in_ready low, flags frozen
    alu(OP_ADD, 16'h0001, 16'h0001, 4'd0, 4'd5);
    tick();
    chk16("stall_pre.data", out_data, 16'h0002);
    chk_flags("stall_pre", 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    alu(OP_ADD, 16'h8002, 16'h8002, 4'd0, 4'd6);
    #1;
    chk1("stall.ready", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("stall.ready_hold", in_ready, 1'b0);
      chk1("stall.valid", out_valid, 1'b1);
      chk16("stall.data", out_data, 16'h0002);
      chk16("stall.dst", {12'b0, out_dst_reg}, 16'h0005);
      chk_flags("stall", 1'b0, 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk1("release.ready", in_ready, 1'b1);
    tick();
    chk16("release0.data", out_data, 16'h8000);
    chk16("release0.dst", {12'b0, out_dst_reg}, 16'h0006);
    chk_flags("release0", 1'b0, 1'b1, 1'b1);
    alu(OP_ADD, 16'h0003, 16'h0003, 4'd0, 4'd7);
    tick();
    chk1("release1.valid", out_valid, 1'b1);
    chk16("release1.data", out_data, 16'h0006);
    chk16("release1.dst", {12'b0, out_dst_reg}, 16'h0007);
    in_valid = 1'b0;
    alu(OP_ADD, 16'h0000, 16'h0000, 4'd0, 4'd8);
    in_valid = 1'b0;
    tick();
    chk1("drain.valid", out_valid, 1'b0);
    chk16("drain.data", out_data, 16'h0006);
    chk_flags("drain", 1'b0, 1'b0, 1'b0);

    // Reset while a stalled result is in flight
    alu(OP_ADD, 16'h8888, 16'h8888, 4'd0, 4'd3);
    tick();
    out_ready = 1'b0;
    alu(OP_SUB, 16'h0000, 16'h0001, 4'd0, 4'd4);
    tick();
    chk1("rst2_pre.valid", out_valid, 1'b1);
    chk_flags("rst2_pre", 1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk1("rst2.valid", out_valid, 1'b0);
    chk16("rst2.data", out_data, 16'h0000);
    chk_flags("rst2", 1'b0, 1'b0, 1'b0);
    chk1("rst2.ready", in_ready, 1'b1);
    tick();
    chk1("rst2_noreplay.valid", out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: rst  in  1  synchronous reset, active-high.
REQ-003 SHALL: in_valid  in  1  upstream instruction present.
REQ-004 SHALL: in_ready  out  1  block accepts the instruction this cycle.
REQ-005 SHALL: in_op  in  3  ALU op: 000 ADD, 001 LHB, 010 SUB, 011 AND, 100 NOR, 101 SLL, 110 SRL, 111 SRA.
REQ-006 SHALL: in_src0 / in_src1  in  16 each  operands.
REQ-007 SHALL: in_shamt  in  4  shift amount.
REQ-008 SHALL: in_dst_reg  in  4  destination register index.
REQ-009 SHALL: in_we  in  1  instruction writes a register.
REQ-010 SHALL: in_br  in  1  branch evaluation; ALU result unused.
REQ-011 SHALL: in_cond  in  3  branch condition: 000 NE, 001 EQ, 010 GT, 011 LT, 100 GE, 101 LE, 110 OV, 111 UNCOND.
REQ-012 SHALL: out_valid  out  1  result register holds a result.
REQ-013 SHALL: out_ready  in  1  downstream consumes the result.
REQ-014 SHALL: out_data / out_dst_reg / out_we / out_taken  out  16 / 4 / 1 / 1  registered result fields.
REQ-015 SHALL: flag_z / flag_v / flag_n  out  1 each  architectural flag register.

Function
REQ-016 SHALL: in_ready = !out_valid | out_ready (combinational); a transfer occurs when in_valid & in_ready.
REQ-017 SHALL: drive the ALU combinationally from in_op/in_src0/in_src1/in_shamt; on a transfer, register dst into out_data next edge (latency 1 cycle).
REQ-018 SHALL: on a transfer, copy in_dst_reg into out_dst_reg and (in_we & !in_br) into out_we.
REQ-019 SHALL: out_valid set on transfer; cleared on out_ready & !transfer; held while out_ready=0 (all out_* stable during stall).
REQ-020 SHALL: on simultaneous consume and transfer, load new result with no bubble (full throughput 1/cycle).
REQ-021 SHALL: flags update only on transfer with in_br=0: ADD/SUB -> Z=zr, V=ov, N=dst[15]; AND/NOR/SLL/SRL/SRA -> Z=zr only; LHB -> no change.
REQ-022 SHALL: a branch transfer evaluate in_cond against the flag register value before the edge (already reflecting all previously accepted instructions) and register out_taken: NE !Z, EQ Z, GT !Z&!N, LT N, GE Z|!N, LE N|Z, OV V, UNCOND 1.
REQ-023 SHALL: on branch transfer, out_data = 0x0000, out_we = 0, flags unchanged; non-branch transfers register out_taken=0.
REQ-024 SHALL: no transfer (in_valid=0 or stall) leave flags and out_* unchanged.

Reset
REQ-025 SHALL: while rst=1: out_valid=0, out_data=0x0000, out_dst_reg=0, out_we=0, out_taken=0, flag_z=flag_v=flag_n=0.
REQ-026 SHALL: rst has priority over a simultaneous transfer; an in-flight result is discarded and not replayed.
REQ-027 SHALL: in_ready=1 during and immediately after reset.

Structure
REQ-028 SHALL: op and cond encodings live as localparams in shared package alu_pkg.
REQ-029 SHALL: contain exactly one instance of the existing ALU sub-module; saturation and zr come from it, not duplicated.

Verification
REQ-030 SHALL: ADD 0x8888+0x8888, out_ready=1 -> next cycle out_data=0x8000, flag_v=1, flag_n=1, flag_z=0.
REQ-031 SHALL: SUB 0x0005-0x0005, then branch EQ next cycle -> out_data=0x0000, flag_z=1; branch out_taken=1, out_we=0.
REQ-032 SHALL: LHB src0=0x12AB src1=0x3400 after the SUB above -> out_data=0x34AB, flag_z stays 1.
REQ-033 SHALL: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* and flags frozen; release -> back-to-back results one per cycle, none lost or duplicated.
REQ-034 SHALL: rst pulsed while out_valid=1 and stalled -> next cycle out_valid=0, flags 0, in_ready=1.
REQ-035 SHALL: AND 0xFFFF&0x0000 after ADD set V=1 -> flag_z=1, flag_v=1 retained, flag_n retained.
